// File: rtl/sync_fifo_rx.sv
// UART receive FIFO: buffers bytes from the RX shift logic, serves them on APB
// reads of offset 0x8, and reports status with sticky error flags at offset 0xC.
module sync_fifo_rx #(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int THRESH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_frame_err,
  input  logic          rx_parity_err,
  input  logic          PSEL_UART,
  input  logic          SLVENABLE,
  input  logic          SLVWRITE,
  input  logic [31:0]   SLVADDR,
  output logic [31:0]   SLVRDATA,
  output logic          rd_empty,
  output logic          wr_full,
  output logic [AW:0]   rx_level,
  output logic          rx_irq
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] THR     = (AW+1)'(THRESH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, level_d;
  logic        ovr_q, ovr_d, frm_q, frm_d, par_q, par_d, irq_q, irq_d;
  logic        rd_acc, pop, clr, push_req, ovr_set, push;
  logic [31:0] status;

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure; a byte is
  // taken at the edge it is high, and an APB read pops at the edge ending its access phase.
  always_comb begin
    rd_empty = (wptr_q == rptr_q);
    wr_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    rx_level = wptr_q - rptr_q;
    rd_acc   = PSEL_UART & SLVENABLE & ~SLVWRITE;
    pop      = rd_acc & (SLVADDR[3:0] == 4'h8) & ~rd_empty;
    clr      = rd_acc & (SLVADDR[3:0] == 4'hC);
    push_req = rx_valid & ~rx_frame_err;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is then legal.
    ovr_set  = push_req & wr_full & ~pop;
    push     = push_req & ~ovr_set;
    wptr_d   = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d   = pop ? rptr_q + PTR_ONE : rptr_q;
    level_d  = wptr_d - rptr_d;
    ovr_d    = (ovr_q & ~clr) | ovr_set;
    frm_d    = (frm_q & ~clr) | (rx_valid & rx_frame_err);
    par_d    = (par_q & ~clr) | (rx_valid & rx_parity_err);
    irq_d    = (level_d >= THR) | ovr_d;
  end

  always_comb begin
    status            = '0;
    status[0]         = ~rd_empty;
    status[1]         = wr_full;
    status[2]         = ovr_q;
    status[3]         = frm_q;
    status[4]         = par_q;
    status[8 +: AW+1] = rx_level;
  end

  always_comb begin
    SLVRDATA = '0;
    if (PSEL_UART && !SLVWRITE) begin
      case (SLVADDR[3:0])
        4'h8: if (!rd_empty) SLVRDATA = {24'h0, mem_q[rptr_q[AW-1:0]]};
        4'hC: SLVRDATA = status;
        default: SLVRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovr_q  <= 1'b0;
      frm_q  <= 1'b0;
      par_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovr_q  <= ovr_d;
      frm_q  <= frm_d;
      par_q  <= par_d;
      irq_q  <= irq_d;
    end
  end

  // Storage is not reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wptr_q[AW-1:0]] <= rx_data;
  end

  assign rx_irq = irq_q;

endmodule

// File: tb/tb_sync_fifo_rx.sv
// Bench for sync_fifo_rx: a queue-based model predicts every output each cycle,
// directed scenarios pin literal values, then a randomized phase runs.
module tb_sync_fifo_rx;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int THRESH = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, rx_frame_err = 1'b0, rx_parity_err = 1'b0;
  logic        PSEL_UART = 1'b0, SLVENABLE = 1'b0, SLVWRITE = 1'b0;
  logic [31:0] SLVADDR = '0;
  logic [31:0] SLVRDATA;
  logic        rd_empty, wr_full, rx_irq;
  logic [AW:0] rx_level;

  sync_fifo_rx #(.DEPTH(DEPTH), .AW(AW), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .PSEL_UART(PSEL_UART), .SLVENABLE(SLVENABLE), .SLVWRITE(SLVWRITE),
    .SLVADDR(SLVADDR), .SLVRDATA(SLVRDATA), .rd_empty(rd_empty),
    .wr_full(wr_full), .rx_level(rx_level), .rx_irq(rx_irq)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // behavioural model: contents as a queue, flags as plain bits
  logic [7:0] exp_q[$];
  bit m_ovr, m_frm, m_par, m_irq, m_ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rdata(input logic ps, input logic wr, input logic [31:0] a);
    logic [31:0] s;
    s = '0;
    if (!ps || wr) return '0;
    if (a[3:0] == 4'h8) return (exp_q.size() != 0) ? {24'h0, exp_q[0]} : 32'h0;
    if (a[3:0] == 4'hC) begin
      s[0] = (exp_q.size() != 0);
      s[1] = (exp_q.size() == DEPTH);
      s[2] = m_ovr;
      s[3] = m_frm;
      s[4] = m_par;
      s[8 +: AW+1] = (AW+1)'(exp_q.size());
      return s;
    end
    return '0;
  endfunction

  task automatic m_step(input logic r, input logic v, input logic [7:0] d, input logic fe,
                        input logic pe, input logic ps, input logic en, input logic wr,
                        input logic [31:0] a);
    bit rd, pop, clr, preq, ovr_now;
    if (r) begin
      exp_q.delete();
      m_ovr = 0; m_frm = 0; m_par = 0; m_irq = 0; m_ok = 1;
      return;
    end
    if (!m_ok) return;
    rd      = ps && en && !wr;
    pop     = rd && (a[3:0] == 4'h8) && (exp_q.size() > 0);
    clr     = rd && (a[3:0] == 4'hC);
    preq    = v && !fe;
    ovr_now = preq && (exp_q.size() == DEPTH) && !pop;
    if (pop) void'(exp_q.pop_front());
    if (preq && !ovr_now) exp_q.push_back(d);
    if (clr) begin m_ovr = 0; m_frm = 0; m_par = 0; end
    if (ovr_now) m_ovr = 1;
    if (v && fe) m_frm = 1;
    if (v && pe) m_par = 1;
    m_irq = (exp_q.size() >= THRESH) || m_ovr;
  endtask

  // One clock: drive at negedge, compare all outputs against the model, advance the model.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic fe,
                       input logic pe, input logic ps, input logic en, input logic wr,
                       input logic [31:0] a, output logic [31:0] rdat);
    @(negedge clk);
    rst = r; rx_valid = v; rx_data = d; rx_frame_err = fe; rx_parity_err = pe;
    PSEL_UART = ps; SLVENABLE = en; SLVWRITE = wr; SLVADDR = a;
    #1;
    rdat = SLVRDATA;
    if (m_ok) begin
      chk("rd_empty", 32'(rd_empty), 32'(exp_q.size() == 0));
      chk("wr_full",  32'(wr_full),  32'(exp_q.size() == DEPTH));
      chk("rx_level", 32'(rx_level), 32'(exp_q.size()));
      chk("rx_irq",   32'(rx_irq),   32'(m_irq));
      chk("slvrdata", SLVRDATA, m_rdata(ps, wr, a));
    end
    m_step(r, v, d, fe, pe, ps, en, wr, a);
    @(posedge clk);
  endtask

  // driver tasks
  logic [31:0] dummy;

  task automatic idle();
    cycle(0, 0, 8'h0, 0, 0, 0, 0, 0, 32'h0, dummy);
  endtask

  task automatic push(input logic [7:0] d, input logic fe, input logic pe);
    cycle(0, 1, d, fe, pe, 0, 0, 0, 32'h0, dummy);
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] rdat);
    cycle(0, 0, 8'h0, 0, 0, 1, 0, 0, a, dummy);
    cycle(0, 0, 8'h0, 0, 0, 1, 1, 0, a, rdat);
  endtask

  task automatic read_push(input logic [31:0] a, input logic [7:0] d, output logic [31:0] rdat);
    cycle(0, 0, 8'h0, 0, 0, 1, 0, 0, a, dummy);
    cycle(0, 1, d, 0, 0, 1, 1, 0, a, rdat);
  endtask

  task automatic do_reset();
    cycle(1, 0, 8'h0, 0, 0, 0, 0, 0, 32'h0, dummy);
  endtask

  logic [31:0] rd_v;
  logic [31:0] a;
  logic [7:0]  d;
  int          push_pct;

  initial begin
    m_ok = 0;
    do_reset();
    #1;
    chk("reset_empty", 32'(rd_empty), 32'h1);
    chk("reset_level", 32'(rx_level), 32'h0);
    chk("reset_irq",   32'(rx_irq),   32'h0);
    chk("reset_full",  32'(wr_full),  32'h0);

    // three bytes in, three out
    push(8'h41, 0, 0);
    #1 chk("irq_after_first", 32'(rx_irq), 32'h1);
    push(8'h42, 0, 0);
    push(8'h43, 0, 0);
    #1 chk("level3", 32'(rx_level), 32'h3);
    apb_read(32'h8, rd_v); chk("rd41", rd_v, 32'h41);
    apb_read(32'h8, rd_v); chk("rd42", rd_v, 32'h42);
    apb_read(32'h8, rd_v); chk("rd43", rd_v, 32'h43);
    #1;
    chk("drained_empty", 32'(rd_empty), 32'h1);
    chk("drained_irq",   32'(rx_irq),   32'h0);

    // overfill: ninth byte is dropped
    for (int i = 0; i < 9; i++) push(8'(i), 0, 0);
    #1 chk("full_after_8", 32'(wr_full), 32'h1);
    apb_read(32'hC, rd_v); chk("status_ovr",   rd_v, 32'h0807);
    apb_read(32'hC, rd_v); chk("status_clear", rd_v, 32'h0803);

    // pop and push together while full
    read_push(32'h8, 8'h55, rd_v); chk("pop_full_rd0", rd_v, 32'h00);
    #1 chk("level_stays_8", 32'(rx_level), 32'h8);
    apb_read(32'hC, rd_v); chk("no_overrun", rd_v, 32'h0803);
    for (int i = 1; i < 8; i++) begin
      apb_read(32'h8, rd_v); chk("drain_seq", rd_v, 32'(i));
    end
    apb_read(32'h8, rd_v); chk("rd55", rd_v, 32'h55);

    // frame error discards, parity error keeps
    push(8'hAA, 1, 0);
    push(8'hBB, 0, 1);
    apb_read(32'hC, rd_v); chk("status_errs", rd_v, 32'h0119);
    apb_read(32'hC, rd_v); chk("status_errs_clr", rd_v, 32'h0101);
    apb_read(32'h8, rd_v); chk("rdBB", rd_v, 32'hBB);

    // read while empty
    apb_read(32'h8, rd_v); chk("rd_empty_zero", rd_v, 32'h0);
    push(8'h5A, 0, 0);
    apb_read(32'h8, rd_v); chk("rd5A", rd_v, 32'h5A);

    // wrap: 20 push/pop pairs carry the pointers through several MSB toggles
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h60 + i), 0, 0);
      apb_read(32'h8, rd_v); chk("wrap_rd", rd_v, 32'(8'h60 + i));
    end
    for (int i = 0; i < 8; i++) push(8'(8'h80 + i), 0, 0);
    #1 chk("wrap_full", 32'(wr_full), 32'h1);
    for (int i = 0; i < 8; i++) begin
      apb_read(32'h8, rd_v); chk("wrap_full_rd", rd_v, 32'(8'h80 + i));
    end

    // reset mid-stream with a simultaneous push
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i), 0, 0);
    #1 chk("level5", 32'(rx_level), 32'h5);
    cycle(1, 1, 8'hEE, 0, 0, 1, 1, 0, 32'h8, dummy);
    #1;
    chk("rst_level", 32'(rx_level), 32'h0);
    chk("rst_empty", 32'(rd_empty), 32'h1);
    chk("rst_irq",   32'(rx_irq),   32'h0);
    apb_read(32'hC, rd_v); chk("rst_status", rd_v, 32'h0);

    // randomized traffic, push rate varies by phase
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 3)
        0: push_pct = 60;
        1: push_pct = 15;
        default: push_pct = 35;
      endcase
      a = $urandom();
      case ($urandom_range(0, 4))
        0, 1: a[3:0] = 4'h8;
        2: a[3:0] = 4'hC;
        3: a[3:0] = 4'h0;
        default: a[3:0] = 4'h4;
      endcase
      d = 8'($urandom());
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < push_pct), d,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 4) == 0), a, dummy);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
